// File: rtl/command_fetch_pkg.sv
// Shared CPU fetch definitions: default word/address widths, fetch FSM encoding
// and command buffer depth (2 when PREFETCH_BUFFER_EN is defined, otherwise 1).
package command_fetch_pkg;

    localparam int DEFAULT_DATA_W = 14;
    localparam int DEFAULT_ADDR_W = 12;

`ifdef PREFETCH_BUFFER_EN
    localparam int CMD_BUF_DEPTH = 2;
`else
    localparam int CMD_BUF_DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2,
        PUSH   = 2'd3
    } fetch_state_t;

    // A single-entry buffer still needs a 1-bit pointer to stay legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/command_fetch_if.sv
// Command handshake between the fetch unit (master) and the decode stage (slave).
interface command_fetch_if
    import command_fetch_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic [2*DATA_W-1:0] command_in;
    logic                comm_valid;
    logic                comm_read;

    modport master (output command_in, output comm_valid, input comm_read);
    modport slave  (input command_in, input comm_valid, output comm_read);
endinterface

// File: rtl/command_fetch_cmd_fifo.sv
// Small command FIFO with synchronous flush; head reads as zero while empty.
module cmd_fifo
    import command_fetch_pkg::*;
#(
    parameter int WIDTH = 2 * DEFAULT_DATA_W,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CAP  = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CAP);
    assign do_pop  = pop && !empty;
    // A full buffer may still accept a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/command_fetch.sv
// Instruction fetch: reads two RAM words per command into a buffer for decode.
// Define PREFETCH_BUFFER_EN for a 2-entry buffer that keeps fetching ahead.
module command_fetch
    import command_fetch_pkg::*;
#(
    parameter int                DATA_W   = DEFAULT_DATA_W,
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pause_FETCH,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_value,
    output logic               ram_rd,
    input  logic               ram_garant_rd,
    output wire  [ADDR_W-1:0]  addr_out,
    input  logic [DATA_W-1:0]  data_in,
    command_fetch_if.master    cmd
);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO = ADDR_W'(2);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] lo_word;
    logic [DATA_W-1:0] hi_word;
    logic              buf_full;
    logic              buf_empty;
    logic              buf_push;

    assign addr_out = ram_rd ? addr_q : {ADDR_W{1'bz}};
    assign buf_push = (state == PUSH) && !pc_load;

    cmd_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (CMD_BUF_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (buf_push),
        .pop   (cmd.comm_read),
        .flush (pc_load),
        .wdata ({hi_word, lo_word}),
        .head  (cmd.command_in),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign cmd.comm_valid = !buf_empty;

    // ram_rd and the address are registered alongside the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            ram_rd  <= 1'b0;
            addr_q  <= '0;
            lo_word <= '0;
            hi_word <= '0;
        end else if (pc_load) begin
            state  <= IDLE;
            pc     <= pc_value;
            ram_rd <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!buf_full && !pause_FETCH) begin
                        state  <= REQ_LO;
                        ram_rd <= 1'b1;
                        addr_q <= pc;
                    end
                end
                REQ_LO: begin
                    if (ram_garant_rd) begin
                        lo_word <= data_in;
                        state   <= REQ_HI;
                        addr_q  <= pc + ONE;
                    end
                end
                REQ_HI: begin
                    if (ram_garant_rd) begin
                        hi_word <= data_in;
                        state   <= PUSH;
                        ram_rd  <= 1'b0;
                    end
                end
                PUSH: begin
                    pc    <= pc + TWO;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_command_fetch.sv
// Scoreboard bench for command_fetch: expected commands are queued from a RAM image.
module tb_command_fetch;

    localparam int DW = 14;
    localparam int AW = 12;

    logic          clk;
    logic          reset;
    logic          pause_FETCH;
    logic          pc_load;
    logic [AW-1:0] pc_value;
    logic          ram_rd;
    logic          ram_garant_rd;
    wire  [AW-1:0] addr_out;
    logic [DW-1:0] data_in;

    logic [DW-1:0]   mem [0:4095];
    logic [2*DW-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    command_fetch_if #(.DATA_W(DW)) cmd_if ();

    command_fetch #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RESET_PC (12'h000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pause_FETCH   (pause_FETCH),
        .pc_load       (pc_load),
        .pc_value      (pc_value),
        .ram_rd        (ram_rd),
        .ram_garant_rd (ram_garant_rd),
        .addr_out      (addr_out),
        .data_in       (data_in),
        .cmd           (cmd_if)
    );

    assign data_in = ram_rd ? mem[addr_out] : '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected commands in fetch order, starting from a given pc with address wrap.
    task automatic queue_from(input logic [AW-1:0] start);
        logic [AW-1:0] a;
        a = start;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({mem[a + 12'd1], mem[a]});
            a = a + 12'd2;
        end
    endtask

    task automatic apply_reset(input logic g, input logic p);
        reset         = 1'b0;
        pc_load       = 1'b0;
        pc_value      = '0;
        cmd_if.comm_read = 1'b0;
        ram_garant_rd = g;
        pause_FETCH   = p;
        repeat (2) tick();
        reset = 1'b1;
        queue_from(12'h000);
    endtask

    task automatic pop_cmd();
        cmd_if.comm_read = 1'b1;
        if (exp_q.size() > 0) exp_q.delete(0);
        tick();
        cmd_if.comm_read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pause_FETCH = 1'b0;
        pc_load = 1'b0;
        pc_value = '0;
        ram_garant_rd = 1'b1;
        cmd_if.comm_read = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ram_rd !== 1'b0) begin errors++; $display("FAIL reset_ram_rd: got %b want 0", ram_rd); end
        tick();
        checks++;
        if (cmd_if.comm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cmd_if.comm_valid); end
        checks++;
        if (cmd_if.command_in !== '0) begin errors++; $display("FAIL reset_command: got %h want 0", cmd_if.command_in); end
    endtask

    task automatic test_basic();
        logic [2*DW-1:0] first_cmd;
        first_cmd = {14'h0567, 14'h1234};
        apply_reset(1'b1, 1'b0);
        tick();
        checks++;
        if (ram_rd !== 1'b1 || addr_out !== 12'h000) begin errors++; $display("FAIL basic_lo: ram_rd=%b addr=%h want 1/000", ram_rd, addr_out); end
        tick();
        checks++;
        if (ram_rd !== 1'b1 || addr_out !== 12'h001 || cmd_if.comm_valid !== 1'b0) begin
            errors++; $display("FAIL basic_hi: ram_rd=%b addr=%h valid=%b want 1/001/0", ram_rd, addr_out, cmd_if.comm_valid);
        end
        tick();
        checks++;
        if (ram_rd !== 1'b0 || cmd_if.comm_valid !== 1'b0) begin errors++; $display("FAIL basic_push: ram_rd=%b valid=%b want 0/0", ram_rd, cmd_if.comm_valid); end
        tick();
        checks++;
        if (cmd_if.comm_valid !== 1'b1 || cmd_if.command_in !== first_cmd) begin
            errors++; $display("FAIL basic_cmd: valid=%b cmd=%h want 1/%h", cmd_if.comm_valid, cmd_if.command_in, first_cmd);
        end
        checks++;
        if (cmd_if.command_in !== exp_q[0]) begin errors++; $display("FAIL basic_scoreboard: got %h want %h", cmd_if.command_in, exp_q[0]); end
        pop_cmd();
        checks++;
        if (cmd_if.comm_valid !== 1'b0) begin errors++; $display("FAIL basic_pop: valid=%b want 0", cmd_if.comm_valid); end
    endtask

    task automatic test_grant_stall();
        apply_reset(1'b1, 1'b0);
        tick();
        tick();
        ram_garant_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ram_rd !== 1'b1 || addr_out !== 12'h001) begin errors++; $display("FAIL stall_hold%0d: ram_rd=%b addr=%h want 1/001", i, ram_rd, addr_out); end
        end
        ram_garant_rd = 1'b1;
        tick();
        checks++;
        if (ram_rd !== 1'b0 || cmd_if.comm_valid !== 1'b0) begin errors++; $display("FAIL stall_capture: ram_rd=%b valid=%b want 0/0", ram_rd, cmd_if.comm_valid); end
        tick();
        checks++;
        if (cmd_if.comm_valid !== 1'b1 || cmd_if.command_in !== exp_q[0]) begin
            errors++; $display("FAIL stall_cmd: valid=%b cmd=%h want 1/%h", cmd_if.comm_valid, cmd_if.command_in, exp_q[0]);
        end
    endtask

    task automatic test_pc_load_wrap();
        logic found;
        apply_reset(1'b1, 1'b0);
`ifdef PREFETCH_BUFFER_EN
        repeat (6) tick();
        checks++;
        if (cmd_if.comm_valid !== 1'b1 || addr_out !== 12'h003) begin
            errors++; $display("FAIL load_setup: valid=%b addr=%h want 1/003", cmd_if.comm_valid, addr_out);
        end
`else
        repeat (2) tick();
`endif
        pc_load  = 1'b1;
        pc_value = 12'hFFF;
        tick();
        pc_load  = 1'b0;
        queue_from(12'hFFF);
        checks++;
        if (cmd_if.comm_valid !== 1'b0 || ram_rd !== 1'b0) begin errors++; $display("FAIL load_flush: valid=%b ram_rd=%b want 0/0", cmd_if.comm_valid, ram_rd); end
        tick();
        checks++;
        if (ram_rd !== 1'b1 || addr_out !== 12'hFFF) begin errors++; $display("FAIL load_lo: ram_rd=%b addr=%h want 1/fff", ram_rd, addr_out); end
        tick();
        checks++;
        if (ram_rd !== 1'b1 || addr_out !== 12'h000) begin errors++; $display("FAIL load_wrap_hi: ram_rd=%b addr=%h want 1/000", ram_rd, addr_out); end
        repeat (2) tick();
        checks++;
        if (cmd_if.comm_valid !== 1'b1 || cmd_if.command_in !== exp_q[0]) begin
            errors++; $display("FAIL load_cmd: valid=%b cmd=%h want 1/%h", cmd_if.comm_valid, cmd_if.command_in, exp_q[0]);
        end
        pop_cmd();
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ram_rd) begin found = 1'b1; break; end
            tick();
        end
        checks++;
        if (found !== 1'b1 || addr_out !== 12'h001) begin errors++; $display("FAIL load_next_pc: seen=%b addr=%h want 1/001", found, addr_out); end
    endtask

    task automatic test_pause();
        apply_reset(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ram_rd !== 1'b0) begin errors++; $display("FAIL pause_idle%0d: ram_rd=%b want 0", i, ram_rd); end
        end
        pause_FETCH = 1'b0;
        tick();
        pause_FETCH = 1'b1;
        checks++;
        if (ram_rd !== 1'b1 || addr_out !== 12'h000) begin errors++; $display("FAIL pause_start: ram_rd=%b addr=%h want 1/000", ram_rd, addr_out); end
        tick();
        checks++;
        if (ram_rd !== 1'b1 || addr_out !== 12'h001) begin errors++; $display("FAIL pause_inflight: ram_rd=%b addr=%h want 1/001", ram_rd, addr_out); end
        repeat (2) tick();
        checks++;
        if (cmd_if.comm_valid !== 1'b1 || cmd_if.command_in !== exp_q[0]) begin
            errors++; $display("FAIL pause_cmd: valid=%b cmd=%h want 1/%h", cmd_if.comm_valid, cmd_if.command_in, exp_q[0]);
        end
        repeat (2) tick();
        checks++;
        if (ram_rd !== 1'b0) begin errors++; $display("FAIL pause_hold: ram_rd=%b want 0", ram_rd); end
        pause_FETCH = 1'b0;
    endtask

    task automatic test_back_to_back();
`ifdef PREFETCH_BUFFER_EN
        apply_reset(1'b1, 1'b0);
        repeat (8) tick();
        checks++;
        if (cmd_if.comm_valid !== 1'b1 || cmd_if.command_in !== exp_q[0]) begin
            errors++; $display("FAIL b2b_head: valid=%b cmd=%h want 1/%h", cmd_if.comm_valid, cmd_if.command_in, exp_q[0]);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ram_rd !== 1'b0) begin errors++; $display("FAIL b2b_full%0d: ram_rd=%b want 0", i, ram_rd); end
        end
        pop_cmd();
        tick();
        checks++;
        if (ram_rd !== 1'b1 || addr_out !== 12'h004) begin errors++; $display("FAIL b2b_resume: ram_rd=%b addr=%h want 1/004", ram_rd, addr_out); end
        tick();
        checks++;
        if (ram_rd !== 1'b1 || addr_out !== 12'h005) begin errors++; $display("FAIL b2b_hi: ram_rd=%b addr=%h want 1/005", ram_rd, addr_out); end
        tick();
        checks++;
        if (cmd_if.command_in !== exp_q[0]) begin errors++; $display("FAIL b2b_second: got %h want %h", cmd_if.command_in, exp_q[0]); end
        pop_cmd();
        checks++;
        if (cmd_if.comm_valid !== 1'b1 || cmd_if.command_in !== exp_q[0]) begin
            errors++; $display("FAIL b2b_push_pop: valid=%b cmd=%h want 1/%h", cmd_if.comm_valid, cmd_if.command_in, exp_q[0]);
        end
        pop_cmd();
        checks++;
        if (cmd_if.comm_valid !== 1'b0) begin errors++; $display("FAIL b2b_occupancy: valid=%b want 0", cmd_if.comm_valid); end
`else
        logic found;
        apply_reset(1'b1, 1'b0);
        repeat (4) tick();
        checks++;
        if (cmd_if.command_in !== exp_q[0]) begin errors++; $display("FAIL b2b_first: got %h want %h", cmd_if.command_in, exp_q[0]); end
        repeat (2) tick();
        checks++;
        if (ram_rd !== 1'b0) begin errors++; $display("FAIL b2b_full: ram_rd=%b want 0", ram_rd); end
        pop_cmd();
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_if.comm_valid) begin found = 1'b1; break; end
            tick();
        end
        checks++;
        if (found !== 1'b1 || cmd_if.command_in !== exp_q[0]) begin
            errors++; $display("FAIL b2b_second: seen=%b cmd=%h want 1/%h", found, cmd_if.command_in, exp_q[0]);
        end
`endif
    endtask

    task automatic test_reset_mid_fetch();
        apply_reset(1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (ram_rd !== 1'b1 || addr_out !== 12'h000) begin errors++; $display("FAIL midrst_req: ram_rd=%b addr=%h want 1/000", ram_rd, addr_out); end
        reset = 1'b0;
        #1;
        checks++;
        if (ram_rd !== 1'b0 || cmd_if.comm_valid !== 1'b0) begin errors++; $display("FAIL midrst_async: ram_rd=%b valid=%b want 0/0", ram_rd, cmd_if.comm_valid); end
        tick();
        ram_garant_rd = 1'b1;
        reset = 1'b1;
        queue_from(12'h000);
        tick();
        checks++;
        if (ram_rd !== 1'b1 || addr_out !== 12'h000 || cmd_if.comm_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_restart: ram_rd=%b addr=%h valid=%b want 1/000/0", ram_rd, addr_out, cmd_if.comm_valid);
        end
        repeat (3) tick();
        checks++;
        if (cmd_if.comm_valid !== 1'b1 || cmd_if.command_in !== exp_q[0]) begin
            errors++; $display("FAIL midrst_cmd: valid=%b cmd=%h want 1/%h", cmd_if.comm_valid, cmd_if.command_in, exp_q[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)
            mem[i] = 14'((i * 97 + 5) ^ (i << 5));
        mem[0] = 14'h1234;
        mem[1] = 14'h0567;
        mem[4095] = 14'h2ABC;
        test_reset();
        test_basic();
        test_grant_stall();
        test_pc_load_wrap();
        test_pause();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
